// File: rtl/reg_file_if.sv
// Issuer and reorder-buffer ports of the architectural register file.
// The master side drives requests and commits; the slave side returns operands.
interface reg_file_if #(
    parameter int REG_ID_WIDTH = 5,
    parameter int XLEN         = 32,
    parameter int ROB_ID_WIDTH = 4
);
    // Issue side: the destination record and the two source reads.
    logic                    valid_from_issuer;
    logic [REG_ID_WIDTH-1:0] rd_from_issuer;
    logic [ROB_ID_WIDTH-1:0] dest_from_issuer;
    logic [REG_ID_WIDTH-1:0] rs1_from_issuer;
    logic [REG_ID_WIDTH-1:0] rs2_from_issuer;
    logic [ROB_ID_WIDTH-1:0] qj_to_issuer;
    logic [XLEN-1:0]         vj_to_issuer;
    logic [ROB_ID_WIDTH-1:0] qk_to_issuer;
    logic [XLEN-1:0]         vk_to_issuer;

    // Reorder-buffer side: the commit port and the flush.
    logic [ROB_ID_WIDTH-1:0] dest_from_rob;
    logic [REG_ID_WIDTH-1:0] rd_from_rob;
    logic [XLEN-1:0]         value_from_rob;
    logic                    reset_from_rob_bus;

    modport master (
        output valid_from_issuer, rd_from_issuer, dest_from_issuer,
        output rs1_from_issuer, rs2_from_issuer,
        output dest_from_rob, rd_from_rob, value_from_rob, reset_from_rob_bus,
        input  qj_to_issuer, vj_to_issuer, qk_to_issuer, vk_to_issuer
    );

    modport slave (
        input  valid_from_issuer, rd_from_issuer, dest_from_issuer,
        input  rs1_from_issuer, rs2_from_issuer,
        input  dest_from_rob, rd_from_rob, value_from_rob, reset_from_rob_bus,
        output qj_to_issuer, vj_to_issuer, qk_to_issuer, vk_to_issuer
    );
endinterface

// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags.
// Reads are combinational, with a bypass from the same-cycle commit.
module reg_file #(
    parameter int REG_COUNT    = 32,
    parameter int REG_ID_WIDTH = 5,
    parameter int XLEN         = 32,
    parameter int ROB_ID_WIDTH = 4
) (
    input logic       clk,
    input logic       rst,
    input logic       rdy,
    reg_file_if.slave bus
);

    logic [XLEN-1:0]         value [REG_COUNT];
    logic [ROB_ID_WIDTH-1:0] tag   [REG_COUNT];

    logic [REG_ID_WIDTH-1:0] rs1;
    logic [REG_ID_WIDTH-1:0] rs2;
    logic [REG_ID_WIDTH-1:0] rd_commit;
    logic                    commit;

    assign rs1       = bus.rs1_from_issuer;
    assign rs2       = bus.rs2_from_issuer;
    assign rd_commit = bus.rd_from_rob;
    assign commit    = (bus.dest_from_rob != '0);

    // The issue on this same cycle is not forwarded; only the commit is.
    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        bus.qj_to_issuer = '0;
        bus.vj_to_issuer = '0;
        bus.qk_to_issuer = '0;
        bus.vk_to_issuer = '0;
        if (rs1 != '0) begin
            if (commit && rd_commit == rs1 && tag[rs1] == bus.dest_from_rob) begin
                bus.vj_to_issuer = bus.value_from_rob;
            end else begin
                bus.qj_to_issuer = tag[rs1];
                bus.vj_to_issuer = value[rs1];
            end
        end
        if (rs2 != '0) begin
            if (commit && rd_commit == rs2 && tag[rs2] == bus.dest_from_rob) begin
                bus.vk_to_issuer = bus.value_from_rob;
            end else begin
                bus.qk_to_issuer = tag[rs2];
                bus.vk_to_issuer = value[rs2];
            end
        end
    end

    // Later assignments win: flush overrides issue, issue overrides commit's tag clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: this storage is deliberately reset; registers must read 0 after reset.
            for (int i = 0; i < REG_COUNT; i++) begin
                value[i] <= '0;
                tag[i]   <= '0;
            end
        end else if (rdy) begin
            // NOTE: non-blocking only, so every read below sees the pre-edge state.
            if (commit && rd_commit != '0) begin
                value[rd_commit] <= bus.value_from_rob;
                if (tag[rd_commit] == bus.dest_from_rob) begin
                    tag[rd_commit] <= '0;
                end
            end
            if (bus.reset_from_rob_bus) begin
                for (int i = 0; i < REG_COUNT; i++) begin
                    tag[i] <= '0;
                end
            end else if (bus.valid_from_issuer && bus.rd_from_issuer != '0) begin
                tag[bus.rd_from_issuer] <= bus.dest_from_issuer;
            end
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Directed vector bench for reg_file: each vector drives one cycle of inputs,
// checks the combinational read outputs before the edge, then lets the edge happen.
module tb_reg_file;

    logic clk;
    logic rst;
    logic rdy;

    reg_file_if #(.REG_ID_WIDTH(5), .XLEN(32), .ROB_ID_WIDTH(4)) bus ();

    reg_file #(
        .REG_COUNT(32), .REG_ID_WIDTH(5), .XLEN(32), .ROB_ID_WIDTH(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        valid;
        logic [4:0]  rd_iss;
        logic [3:0]  dest_iss;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [3:0]  dest_rob;
        logic [4:0]  rd_rob;
        logic [31:0] value_rob;
        logic        flush;
        logic [3:0]  exp_qj;
        logic [31:0] exp_vj;
        logic [3:0]  exp_qk;
        logic [31:0] exp_vk;
    } vec_t;

    vec_t vq[$];
    int   total;
    int   bad;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic add(input logic r, input logic valid, input int rd_iss, input int dest_iss,
                       input int rs1, input int rs2, input int dest_rob, input int rd_rob,
                       input logic [31:0] value_rob, input logic flush,
                       input int qj, input logic [31:0] vj, input int qk, input logic [31:0] vk);
        vec_t v;
        v.rdy       = r;
        v.valid     = valid;
        v.rd_iss    = 5'(rd_iss);
        v.dest_iss  = 4'(dest_iss);
        v.rs1       = 5'(rs1);
        v.rs2       = 5'(rs2);
        v.dest_rob  = 4'(dest_rob);
        v.rd_rob    = 5'(rd_rob);
        v.value_rob = value_rob;
        v.flush     = flush;
        v.exp_qj    = 4'(qj);
        v.exp_vj    = vj;
        v.exp_qk    = 4'(qk);
        v.exp_vk    = vk;
        vq.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        rdy                    = v.rdy;
        bus.valid_from_issuer  = v.valid;
        bus.rd_from_issuer     = v.rd_iss;
        bus.dest_from_issuer   = v.dest_iss;
        bus.rs1_from_issuer    = v.rs1;
        bus.rs2_from_issuer    = v.rs2;
        bus.dest_from_rob      = v.dest_rob;
        bus.rd_from_rob        = v.rd_rob;
        bus.value_from_rob     = v.value_rob;
        bus.reset_from_rob_bus = v.flush;
    endtask

    task automatic check_reads(input string tag_name, input int qj, input logic [31:0] vj,
                               input int qk, input logic [31:0] vk);
        check({tag_name, "_qj"}, 32'(bus.qj_to_issuer), 32'(qj));
        check({tag_name, "_vj"}, bus.vj_to_issuer, vj);
        check({tag_name, "_qk"}, 32'(bus.qk_to_issuer), 32'(qk));
        check({tag_name, "_vk"}, bus.vk_to_issuer, vk);
    endtask

    initial begin
        vec_t idle;
        total = 0;
        bad   = 0;

        //   rdy vld rdI dsI rs1 rs2 dsR rdR valR        fl   qj vj          qk vk
        add(1, 0,  0,  0,  5, 31,  0,  0, 32'h0,      0,   0, 32'h0,      0, 32'h0);    // reset state
        add(1, 1,  3,  2,  3,  0,  0,  0, 32'h0,      0,   0, 32'h0,      0, 32'h0);    // issue not forwarded
        add(1, 0,  0,  0,  3,  0,  0,  0, 32'h0,      0,   2, 32'h0,      0, 32'h0);    // tag visible
        add(1, 0,  0,  0,  3,  3,  2,  3, 32'h1234,   0,   0, 32'h1234,   0, 32'h1234); // commit bypass
        add(1, 0,  0,  0,  3,  3,  0,  0, 32'h0,      0,   0, 32'h1234,   0, 32'h1234);
        add(1, 1,  4,  1,  3,  0,  0,  0, 32'h0,      0,   0, 32'h1234,   0, 32'h0);
        add(1, 1,  4,  5,  4,  4,  0,  0, 32'h0,      0,   1, 32'h0,      1, 32'h0);
        add(1, 0,  0,  0,  4,  4,  1,  4, 32'h7,      0,   5, 32'h0,      5, 32'h0);    // stale commit, no bypass
        add(1, 0,  0,  0,  4,  4,  0,  0, 32'h0,      0,   5, 32'h7,      5, 32'h7);
        add(1, 1,  6,  2,  6,  0,  0,  0, 32'h0,      0,   0, 32'h0,      0, 32'h0);
        add(1, 1,  6,  3,  6,  6,  2,  6, 32'h9,      0,   0, 32'h9,      0, 32'h9);    // same-edge issue+commit
        add(1, 0,  0,  0,  6,  6,  0,  0, 32'h0,      0,   3, 32'h9,      3, 32'h9);
        add(1, 1,  0,  4,  0,  0,  4,  0, 32'hFFFF,   0,   0, 32'h0,      0, 32'h0);    // writes to x0
        add(1, 0,  0,  0,  0,  0,  0,  0, 32'h0,      0,   0, 32'h0,      0, 32'h0);
        add(1, 1,  1,  6,  0,  0,  0,  0, 32'h0,      0,   0, 32'h0,      0, 32'h0);
        add(1, 1,  2,  7,  0,  0,  0,  0, 32'h0,      0,   0, 32'h0,      0, 32'h0);
        add(1, 1,  7,  8,  1,  2,  0,  0, 32'h0,      0,   6, 32'h0,      7, 32'h0);
        add(1, 1,  5, 10,  7,  5,  9,  7, 32'hAB,     1,   8, 32'h0,      0, 32'h0);    // flush + commit + issue
        add(1, 0,  0,  0,  7,  5,  0,  0, 32'h0,      0,   0, 32'hAB,     0, 32'h0);
        add(1, 0,  0,  0,  6,  4,  0,  0, 32'h0,      0,   0, 32'h9,      0, 32'h7);
        add(1, 0,  0,  0,  1,  2,  0,  0, 32'h0,      0,   0, 32'h0,      0, 32'h0);
        add(1, 1,  8, 12,  0,  0,  0,  0, 32'h0,      0,   0, 32'h0,      0, 32'h0);
        add(0, 1,  3, 11,  3,  3, 12,  8, 32'h55,     1,   0, 32'h1234,   0, 32'h1234); // frozen
        add(1, 0,  0,  0,  8,  3,  0,  0, 32'h0,      0,  12, 32'h0,      0, 32'h1234);

        idle = vq[0];
        idle.rs1 = '0;
        idle.rs2 = '0;
        drive(idle);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i]);
            #1;
            check_reads($sformatf("v%0d", i), int'(vq[i].exp_qj), vq[i].exp_vj,
                        int'(vq[i].exp_qk), vq[i].exp_vk);
        end

        // Asynchronous reset between edges clears state without a clock.
        @(negedge clk);
        drive(idle);
        bus.rs1_from_issuer = 5'd3;
        bus.rs2_from_issuer = 5'd8;
        #1;
        check_reads("pre_rst", 0, 32'h1234, 12, 32'h0);
        rst = 1'b0;
        #1;
        check_reads("async_rst", 0, 32'h0, 0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        bus.rs1_from_issuer = 5'd4;
        bus.rs2_from_issuer = 5'd7;
        #1;
        check_reads("post_rst", 0, 32'h0, 0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
Architectural register file with per-register rename tags. It sits downstream of the reorder buffer and upstream of the issuer. The reorder buffer's commit port writes retired values here. The issuer reads rs1/rs2 operands (value, or the tag of the producing entry) and records the new producer of rd on every issue. A reorder-buffer flush clears all pending tags; architectural values are kept.

Parameters:
REG_COUNT, 32, number of architectural registers; x0 is hardwired to zero.
REG_ID_WIDTH, 5, width of a register index.
XLEN, 32, register data width.
ROB_ID_WIDTH, 4, width of a reorder-buffer entry id; id 0 means "no producer / invalid".

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous reset, active-low.
rdy  in  1  global ready; when low, all state is frozen and outputs hold.
valid_from_issuer  in  1  issue this cycle; record a new producer for rd.
rd_from_issuer  in  REG_ID_WIDTH  destination register of the issued instruction.
dest_from_issuer  in  ROB_ID_WIDTH  reorder-buffer entry allocated to that instruction.
rs1_from_issuer  in  REG_ID_WIDTH  source register 1 index.
rs2_from_issuer  in  REG_ID_WIDTH  source register 2 index.
qj_to_issuer  out  ROB_ID_WIDTH  producer tag of rs1; 0 means the value is ready.
vj_to_issuer  out  XLEN  value of rs1; meaningful only when qj is 0.
qk_to_issuer  out  ROB_ID_WIDTH  producer tag of rs2.
vk_to_issuer  out  XLEN  value of rs2.
dest_from_rob  in  ROB_ID_WIDTH  committing entry id; 0 means no commit.
rd_from_rob  in  REG_ID_WIDTH  committing destination register.
value_from_rob  in  XLEN  committing value.
reset_from_rob_bus  in  1  misprediction flush.

Behaviour:
- State: value[REG_COUNT] and tag[REG_COUNT], both registered.
- Reset (rst low, asynchronous):
  - every value and every tag cleared to 0;
  - outputs become combinational functions of the cleared state (all q = 0, all v = 0).
- Read path is purely combinational, zero latency, evaluated for rs1 and rs2 independently:
  - If rs == 0: q = 0, v = 0.
  - Else if dest_from_rob != 0, rd_from_rob == rs and tag[rs] == dest_from_rob (commit bypass): q = 0, v = value_from_rob.
  - Else: q = tag[rs], v = value[rs].
- The read path does not forward the same-cycle issue. An instruction never reads its own rd tag.
- Commit, on a clock edge with rdy=1, rst high and dest_from_rob != 0:
  - if rd_from_rob != 0, value[rd_from_rob] <= value_from_rob;
  - if additionally tag[rd_from_rob] == dest_from_rob, then tag[rd_from_rob] <= 0;
  - a non-matching tag is left unchanged, because a younger producer is pending.
- Issue, on a clock edge with rdy=1, rst high, valid_from_issuer=1 and rd_from_issuer != 0: tag[rd_from_issuer] <= dest_from_issuer.
- Simultaneous issue and commit to the same register: the issue tag wins and the commit value is still written.
- Flush, on a clock edge with rdy=1, rst high and reset_from_rob_bus=1:
  - all tags <= 0 and the same-edge issue is ignored;
  - the same-edge commit value is still written, because the reorder buffer commits before it flushes.
- x0: never written, tag never set, always reads 0/0.
- rdy=0: no state change, regardless of any inputs.
- Writes to rd=0 from either port are silently dropped.

Test Plan:
- After reset, read rs1=5 and rs2=31 -> qj=0, vj=0, qk=0, vk=0.
- Issue rd=3 with dest=2, then read rs1=3 -> qj=2. Commit dest=2, rd=3, value=0x1234 -> the same-cycle read gives qj=0, vj=0x1234; the next cycle gives tag[3]=0, value[3]=0x1234.
- Issue rd=4 with dest=1, then issue rd=4 with dest=5, then commit dest=1, rd=4, value=7 -> value[4]=7, read shows qk=5.
- Same edge: issue rd=6 with dest=3 and commit dest=2, rd=6, value=9 (with tag[6]=2) -> value[6]=9, tag[6]=3.
- Issue rd=0 with dest=4 and commit rd=0 with value 0xFFFF -> reads of x0 return 0/0.
- With tags set on x1, x2, x7: pulse reset_from_rob_bus together with a commit of rd=7, value=0xAB -> all tags 0, value[7]=0xAB.
- rdy=0 with a valid issue and commit -> no state change.
- rst asserted mid-operation -> all state cleared immediately, without waiting for a clock edge.
